// File: rtl/eve_gene_compactor_pkg.sv
// Shared gene definitions for the EvE add-gene engine and its downstream compactor.
// Package eve_gene_pkg: gene width, tag field, node/connection type bit, src/dst ID fields.
package eve_gene_pkg;

   localparam int GENE_W = 64;
   localparam int TAG_HI = GENE_W - 1;
   localparam int TAG_LO = GENE_W - 8;
   localparam logic [7:0] INVALID_TAG = 8'hFF;

   localparam int TYPE_BIT  = 55;
   localparam int SRC_ID_HI = 47;
   localparam int SRC_ID_LO = 32;
   localparam int DST_ID_HI = 31;
   localparam int DST_ID_LO = 16;

   typedef logic [GENE_W-1:0] gene_t;

   typedef enum logic {
      GENE_NODE = 1'b0,
      GENE_CONN = 1'b1
   } gene_kind_e;

   function automatic logic [7:0] gene_tag(input gene_t g);
      return g[TAG_HI:TAG_LO];
   endfunction

   function automatic logic tag_is_live(input logic [7:0] tag);
      return tag != INVALID_TAG;
   endfunction

   function automatic gene_kind_e gene_kind(input gene_t g);
      return gene_kind_e'(g[TYPE_BIT]);
   endfunction

   function automatic logic [SRC_ID_HI-SRC_ID_LO:0] gene_src_id(input gene_t g);
      return g[SRC_ID_HI:SRC_ID_LO];
   endfunction

   function automatic logic [DST_ID_HI-DST_ID_LO:0] gene_dst_id(input gene_t g);
      return g[DST_ID_HI:DST_ID_LO];
   endfunction

   // Saturating accumulate of a 0..3 increment into a 16-bit statistic.
   function automatic logic [15:0] sat_add16(input logic [15:0] acc, input logic [1:0] inc);
      logic [16:0] sum;
      sum = {1'b0, acc} + 17'(inc);
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

endpackage

// File: rtl/eve_gene_compactor_if.sv
// Upstream slot bus and downstream valid/ready bus of the gene compactor.
// EVE_GENE_COMPACTOR_STATS_EN adds the GenesIn / GenesDropped statistics.
interface eve_gene_compactor_if
   import eve_gene_pkg::*;
#(
   parameter int DEPTH = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   gene_t         InGene1;
   gene_t         InGene2;
   gene_t         InGene3;
   logic          InValid;
   logic          InReady;
   gene_t         OutGene;
   logic          OutValid;
   logic          OutReady;
   logic [CW-1:0] Count;
   logic          Overflow;

`ifdef EVE_GENE_COMPACTOR_STATS_EN
   logic [15:0]   GenesIn;
   logic [15:0]   GenesDropped;

   modport master (
      output InGene1, InGene2, InGene3, InValid, OutReady,
      input  InReady, OutGene, OutValid, Count, Overflow, GenesIn, GenesDropped
   );

   modport slave (
      input  InGene1, InGene2, InGene3, InValid, OutReady,
      output InReady, OutGene, OutValid, Count, Overflow, GenesIn, GenesDropped
   );
`else
   modport master (
      output InGene1, InGene2, InGene3, InValid, OutReady,
      input  InReady, OutGene, OutValid, Count, Overflow
   );

   modport slave (
      input  InGene1, InGene2, InGene3, InValid, OutReady,
      output InReady, OutGene, OutValid, Count, Overflow
   );
`endif

endinterface

// File: rtl/eve_gene_compactor_slot_packer.sv
// Combinational slot packer: live mask, live count and hole-free write offsets
// for the three incoming gene slots.
module eve_slot_packer
   import eve_gene_pkg::*;
(
   input  logic       in_valid,
   input  logic [7:0] tag1,
   input  logic [7:0] tag2,
   input  logic [7:0] tag3,
   output logic [2:0] live,
   output logic [1:0] nwr,
   output logic [1:0] off1,
   output logic [1:0] off2,
   output logic [1:0] off3
);

   always_comb begin
      live[0] = in_valid && tag_is_live(tag1);
      live[1] = in_valid && tag_is_live(tag2);
      live[2] = in_valid && tag_is_live(tag3);
      // Each slot lands after however many earlier slots were live.
      off1 = 2'd0;
      off2 = {1'b0, live[0]};
      off3 = {1'b0, live[0]} + {1'b0, live[1]};
      nwr  = off3 + {1'b0, live[2]};
   end

endmodule

// File: rtl/eve_gene_compactor.sv
// Gene compactor: packs up to three live gene slots per cycle into a circular
// buffer and streams them out one per cycle. Optional stats: EVE_GENE_COMPACTOR_STATS_EN.
module eve_gene_compactor
   import eve_gene_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input logic                clk,
   input logic                Reset,
   eve_gene_compactor_if.slave bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 3);

   gene_t         mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count_q;
   logic          overflow_q;

   gene_t         slot [3];
   logic [1:0]    off  [3];
   logic [2:0]    live;
   logic [1:0]    nwr;
   logic          in_ready;
   logic          out_valid;
   logic          accept;
   logic          pop;
   logic          drop;

   assign slot[0] = bus.InGene1;
   assign slot[1] = bus.InGene2;
   assign slot[2] = bus.InGene3;

   eve_slot_packer u_packer (
      .in_valid (bus.InValid),
      .tag1     (gene_tag(bus.InGene1)),
      .tag2     (gene_tag(bus.InGene2)),
      .tag3     (gene_tag(bus.InGene3)),
      .live     (live),
      .nwr      (nwr),
      .off1     (off[0]),
      .off2     (off[1]),
      .off3     (off[2])
   );

   // Ready and valid come from registered occupancy only.
   assign in_ready  = (count_q <= READY_MAX);
   assign out_valid = (count_q != '0);
   assign accept    = bus.InValid && in_ready;
   assign pop       = out_valid && bus.OutReady;
   assign drop      = bus.InValid && !in_ready && (nwr != 2'd0);

   always_ff @(posedge clk) begin
      if (accept) begin
         for (int k = 0; k < 3; k++) begin
            if (live[k]) mem[wr_ptr + PW'(off[k])] <= slot[k];
         end
      end
   end

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + PW'(nwr);
         if (pop)    rd_ptr <= rd_ptr + PW'(1);
         count_q <= count_q + CW'(accept ? nwr : 2'd0) - CW'(pop);
         if (drop)   overflow_q <= 1'b1;
      end
   end

   assign bus.InReady  = in_ready;
   assign bus.OutValid = out_valid;
   assign bus.OutGene  = out_valid ? mem[rd_ptr] : '1;
   assign bus.Count    = count_q;
   assign bus.Overflow = overflow_q;

`ifdef EVE_GENE_COMPACTOR_STATS_EN
   logic [15:0] genes_in_q;
   logic [15:0] genes_dropped_q;

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         genes_in_q      <= '0;
         genes_dropped_q <= '0;
      end else begin
         if (accept) genes_in_q      <= sat_add16(genes_in_q, nwr);
         if (drop)   genes_dropped_q <= sat_add16(genes_dropped_q, nwr);
      end
   end

   assign bus.GenesIn      = genes_in_q;
   assign bus.GenesDropped = genes_dropped_q;
`endif

endmodule

// File: doc/eve_gene_compactor.md
# eve_gene_compactor

Downstream stage of the EvE add-gene engine. Each cycle it takes up to three 64-bit gene slots, discards slots carrying the invalid tag (top byte 8'hFF), and writes the surviving genes in slot order into a circular buffer. Genes leave one per cycle over a valid/ready handshake toward the genome writer. The block flags when upstream issues genes it cannot hold.

## Interface
- GENE_W, 64, gene width; tag field is [GENE_W-1:GENE_W-8]
- DEPTH, 16, buffer entries; power of two, minimum 4
- INVALID_TAG, 8'hFF, tag value marking an empty slot

- clk  input  1  clock; all state updates on the rising edge
- Reset  input  1  asynchronous active-low reset (0 = reset)
- InGene1, InGene2, InGene3  input  GENE_W each  slot genes, in priority order 1→3
- InValid  input  1  slots carry a cycle of engine output
- InReady  output  1  at least 3 entries free
- OutGene  output  GENE_W  head gene; all-ones when empty
- OutValid  output  1  buffer non-empty
- OutReady  input  1  consumer accepts OutGene
- Count  output  $clog2(DEPTH)+1  occupancy
- Overflow  output  1  sticky; upstream issued while InReady=0

## Operation
- Slot k is live when InValid=1 and InGeneK[GENE_W-1:GENE_W-8] != INVALID_TAG.
- Accept: InValid && InReady. Live slots are packed, with no holes, to wr_ptr, wr_ptr+1, wr_ptr+2 (modulo DEPTH) in order 1,2,3. nwr = number of live slots (0..3). Dead slots consume no entry.
- Pop: OutValid && OutReady. rd_ptr advances by 1 modulo DEPTH.
- Count_next = Count + (accepted ? nwr : 0) − pop. Simultaneous push and pop is legal in every state, including Count=0 with push: the pop is suppressed because OutValid=0.
- InReady = (DEPTH − Count) >= 3. It depends only on registered Count, so there is no combinational path from the In* or OutReady ports.
- InValid=1 with InReady=0 and nwr>0: the genes are dropped, no state change except Overflow←1. Overflow clears only on reset. InValid=1 with nwr=0 never sets Overflow.
- OutGene = mem[rd_ptr] when Count>0, else {GENE_W{1'b1}}. OutValid = (Count != 0).
- Memory array is not reset. Pointers, Count and Overflow are reset.

## Timing
- Reset asserted (asynchronous, any time, including mid-burst): wr_ptr=0, rd_ptr=0, Count=0, Overflow=0, OutValid=0, OutGene=all-ones, InReady=1. Release is synchronous to the next clk edge.
- Latency: a gene accepted at edge N appears on OutGene after edge N when the buffer was empty (first-word-fall-through). Throughput is 1 gene out per cycle and 3 in per cycle.
- Head is stable while OutValid=1 and OutReady=0.
- Pointer wrap: DEPTH−1 → 0 within a single 3-entry packed write is required (e.g. wr_ptr=15 writes to 15, 0, 1).

## Configuration
- EVE_GENE_COMPACTOR_STATS_EN defined: adds outputs GenesIn[15:0] and GenesDropped[15:0]. Both reset to 0 and saturate at 16'hFFFF.
  - GenesIn adds nwr on each accept.
  - GenesDropped adds nwr on each overflow event.
- Not defined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package eve_gene_pkg: GENE_W, INVALID_TAG, tag field bounds, node/connection type bit (55), src/dst ID field bounds. The add-gene engine uses the same package.
- Sub-module eve_slot_packer: purely combinational. Computes the live mask, nwr, and per-slot write offsets (0..2), and is instanced once. Pointer, count and memory logic stay in the top.

## Test plan
- Reset: hold Reset=0 mid-traffic → OutValid=0, OutGene=64'hFFFFFFFFFFFFFFFF, Count=0, InReady=1, Overflow=0, immediately and without a clock edge.
- One cycle of slots A, B, C, all live, OutReady=1 → OutGene A, B, C on the three following cycles; Count 3→2→1→0.
- Slots 1 and 3 live, slot 2 = 64'hFF00_0000_0000_0000 → only A and C stored, Count=2, order A then C.
- OutReady=0, five cycles of 3 live genes → Count=15, InReady=0. A sixth InValid with live slots → Overflow=1, Count stays 15. An InValid cycle with all slots dead → Overflow unchanged.
- Preload Count=10 with rd_ptr=14, then push 3 and pop 1 in the same cycle → Count=12. Data is read back correctly across the 15→0 wrap.
- With EVE_GENE_COMPACTOR_STATS_EN defined, repeat the overflow scenario → GenesIn=15, GenesDropped=3.
